// File: rtl/temp_sample_reader_pkg.sv
// Shared types for the temperature sample buffer: reader FSM states, default widths, pointer compare.
// Combinational helpers only, no state; the writer side uses ptr_cmp for its full check.
package temp_sample_reader_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int ADDR_W_DEF = 4;
    localparam int PTR_MAX_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Pointers are zero-extended to PTR_MAX_W; aw is the address width, and bit aw is the wrap bit.
    // want_full=0 returns empty, want_full=1 returns full.
    function automatic logic ptr_cmp(
        input logic [PTR_MAX_W-1:0] rd,
        input logic [PTR_MAX_W-1:0] wr,
        input logic [3:0]           aw,
        input logic                 want_full
    );
        logic [PTR_MAX_W-1:0] lo_mask;
        lo_mask = PTR_MAX_W'((64'd1 << aw) - 64'd1);
        if (want_full)
            return ((rd & lo_mask) == (wr & lo_mask)) && (rd[aw] != wr[aw]);
        return rd == wr;
    endfunction

endpackage

// File: rtl/temp_avg4.sv
// Running mean of the last 4 fetched samples; avg is the mean including the sample being pushed.
// Latency: avg/primed are combinational on push; history updates at the clock edge. No backpressure.
module temp_avg4
    import temp_sample_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg,
    output logic              primed
);

    logic [3:0][DATA_W-1:0] hist;
    logic [DATA_W+1:0]      sum;
    logic [DATA_W+1:0]      sum_nxt;
    logic [1:0]             cnt;

    // History starts zeroed, so the sum stays exact while filling up.
    assign sum_nxt = sum + {2'b00, sample} - {2'b00, hist[3]};
    assign avg     = sum_nxt[DATA_W+1:2];
    assign primed  = (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            sum  <= '0;
            cnt  <= '0;
        end else if (push) begin
            hist <= {hist[2:0], sample};
            sum  <= sum_nxt;
            if (!primed)
                cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/temp_sample_reader.sv
// Drains the sample RAM in order onto a valid/ready stream; AVG4_EN outputs a 4-sample running mean.
// Latency: sample visible 2 cycles after wr_ptr advances, 1 sample per 3 cycles. Holds out_data until out_ready.
module temp_sample_reader
    import temp_sample_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   wr_ptr,
    input  logic              flush,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W:0]   rd_ptr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              empty
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   rd_ptr_nxt;
    logic              out_valid_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic [DATA_W-1:0] fetch_dat;
    logic              fetch_show;

    assign empty    = ptr_cmp(PTR_MAX_W'(rd_ptr), PTR_MAX_W'(wr_ptr), 4'(ADDR_W), 1'b0);
    assign ram_addr = rd_ptr[ADDR_W-1:0];

`ifdef AVG4_EN
    logic avg_push;

    assign avg_push = (state == FETCH) && !flush;

    temp_avg4 #(
        .DATA_W (DATA_W)
    ) u_avg4 (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .push   (avg_push),
        .sample (ram_q),
        .avg    (fetch_dat),
        .primed (fetch_show)
    );
`else
    assign fetch_dat  = ram_q;
    assign fetch_show = 1'b1;
`endif

    always_comb begin
        state_nxt     = state;
        rd_ptr_nxt    = rd_ptr;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        ram_rden      = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    rd_ptr_nxt = wr_ptr;
                end else if (!empty && !rst) begin
                    ram_rden  = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (flush) begin
                    rd_ptr_nxt    = wr_ptr;
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else if (fetch_show) begin
                    out_data_nxt  = fetch_dat;
                    out_valid_nxt = 1'b1;
                    state_nxt     = HOLD;
                end else begin
                    // Averager still filling: the sample is consumed without being presented.
                    rd_ptr_nxt = rd_ptr + PTR_ONE;
                    state_nxt  = IDLE;
                end
            end
            HOLD: begin
                if (flush) begin
                    rd_ptr_nxt    = wr_ptr;
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else if (out_ready) begin
                    rd_ptr_nxt    = rd_ptr + PTR_ONE;
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                out_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            rd_ptr    <= rd_ptr_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end

endmodule

// File: tb/tb_temp_sample_reader.sv
// Self-checking bench for temp_sample_reader: RAM model, scoreboard of expected samples, one task per scenario.
module tb_temp_sample_reader;
    import temp_sample_reader_pkg::*;

    localparam int DW = 12;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW:0]   wr_ptr = '0;
    logic          flush = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_rden;
    logic [DW-1:0] ram_q;
    logic [AW:0]   rd_ptr;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          empty;

    logic [DW-1:0] ram [16];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_log [$];
    int            checks = 0;
    int            errors = 0;

    temp_sample_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_ptr    (wr_ptr),
        .flush     (flush),
        .ram_addr  (ram_addr),
        .ram_rden  (ram_rden),
        .ram_q     (ram_q),
        .rd_ptr    (rd_ptr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rden) begin
            ram_q <= ram[ram_addr];
            addr_log.push_back(ram_addr);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_ptr = '0;
        tick(); tick();
        rst = 1'b0;
        exp_q.delete();
        addr_log.delete();
    endtask

    task automatic set_rd_ptr(input logic [AW:0] p);
        wr_ptr = p; flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_hs(input int budget, output bit ok, output logic [DW-1:0] dat, output int cyc);
        ok = 1'b0; dat = '0; cyc = 0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid && out_ready) begin
                ok = 1'b1; dat = out_data; cyc = i;
                tick();
                return;
            end
            tick();
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b0 || ram_rden !== 1'b0 || empty !== 1'b1 || rd_ptr !== '0 || out_data !== '0) begin
                errors++;
                $display("FAIL reset_idle: valid=%b rden=%b empty=%b rd_ptr=%0d data=%h, required 0 0 1 0 000",
                         out_valid, ram_rden, empty, rd_ptr, out_data);
            end
            tick();
        end
    endtask

    task automatic test_ptr_cmp();
        logic [15:0] a [5];
        logic [15:0] b [5];
        logic        f [5];
        logic        r [5];
        a = '{16'd16, 16'd5, 16'd5, 16'd17, 16'd3};
        b = '{16'd0,  16'd5, 16'd5, 16'd1,  16'd1};
        f = '{1'b1,   1'b1,  1'b0,  1'b1,   1'b1};
        r = '{1'b1,   1'b0,  1'b1,  1'b1,   1'b0};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ptr_cmp(a[i], b[i], 4'd4, f[i]) !== r[i]) begin
                errors++;
                $display("FAIL ptr_cmp[%0d]: got %b, required %b", i, ptr_cmp(a[i], b[i], 4'd4, f[i]), r[i]);
            end
        end
    endtask

    task automatic test_burst();
        bit ok; logic [DW-1:0] dat; logic [DW-1:0] exp; int cyc;
        do_reset();
        out_ready = 1'b1;
        ram[0] = 12'h1A0; ram[1] = 12'h1A4; ram[2] = 12'h1B0;
        for (int i = 0; i < 3; i++) exp_q.push_back(ram[i]);
        wr_ptr = 5'd3;
        for (int i = 0; i < 3; i++) begin
            wait_hs(20, ok, dat, cyc);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL burst_timeout[%0d]: no handshake, required one", i);
            end else begin
                exp = exp_q.pop_front();
                if (dat !== exp) begin
                    errors++;
                    $display("FAIL burst_data[%0d]: got %h, required %h", i, dat, exp);
                end
                checks++;
                if (cyc != 2) begin
                    errors++;
                    $display("FAIL burst_spacing[%0d]: got %0d idle cycles, required 2", i, cyc);
                end
            end
        end
        checks++;
        if (rd_ptr !== 5'd3 || empty !== 1'b1) begin
            errors++;
            $display("FAIL burst_end: rd_ptr=%0d empty=%b, required 3 1", rd_ptr, empty);
        end
    endtask

    task automatic test_stall();
        bit ok; logic [DW-1:0] exp;
        do_reset();
        ram[0] = 12'h321;
        exp_q.push_back(12'h321);
        wr_ptr = 5'd1;
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_timeout: out_valid never rose");
        end else begin
            exp = exp_q.pop_front();
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp || rd_ptr !== 5'd0) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: valid=%b data=%h rd_ptr=%0d, required 1 %h 0",
                             i, out_valid, out_data, rd_ptr, exp);
                end
                tick();
            end
            out_ready = 1'b1;
            tick();
            checks++;
            if (rd_ptr !== 5'd1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_release: rd_ptr=%0d valid=%b, required 1 0", rd_ptr, out_valid);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok; logic [DW-1:0] dat; logic [DW-1:0] exp; int cyc;
        logic [AW:0] exp_ptr [2];
        exp_ptr = '{5'b1_0000, 5'b1_0001};
        do_reset();
        set_rd_ptr(5'd15);
        checks++;
        if (rd_ptr !== 5'd15) begin
            errors++;
            $display("FAIL wrap_setup: rd_ptr=%0d, required 15", rd_ptr);
        end
        addr_log.delete();
        ram[15] = 12'h0FF; ram[0] = 12'h100;
        exp_q.push_back(12'h0FF); exp_q.push_back(12'h100);
        out_ready = 1'b1;
        wr_ptr = 5'b1_0001;
        for (int i = 0; i < 2; i++) begin
            wait_hs(20, ok, dat, cyc);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL wrap_timeout[%0d]: no handshake", i);
            end else begin
                exp = exp_q.pop_front();
                if (dat !== exp || rd_ptr !== exp_ptr[i]) begin
                    errors++;
                    $display("FAIL wrap_step[%0d]: data=%h rd_ptr=%b, required %h %b", i, dat, rd_ptr, exp, exp_ptr[i]);
                end
            end
        end
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 4'd15 || addr_log[1] !== 4'd0) begin
            errors++;
            $display("FAIL wrap_addr: %0d reads, required 2 reads at 15 then 0", addr_log.size());
        end
    endtask

    task automatic test_flush_hold();
        bit ok;
        do_reset();
        set_rd_ptr(5'd4);
        for (int i = 4; i < 9; i++) ram[i] = 12'h400 + 12'(i);
        addr_log.delete();
        out_ready = 1'b0;
        wr_ptr = 5'd9;
        wait_valid(20, ok);
        checks++;
        if (!ok || out_data !== 12'h404) begin
            errors++;
            $display("FAIL flush_hold_pre: valid=%b data=%h, required 1 404", ok, out_data);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || rd_ptr !== 5'd9 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_hold: valid=%b rd_ptr=%0d empty=%b, required 0 9 1", out_valid, rd_ptr, empty);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b0 || ram_rden !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet[%0d]: valid=%b rden=%b, required 0 0", i, out_valid, ram_rden);
            end
            tick();
        end
        checks++;
        if (addr_log.size() != 1) begin
            errors++;
            $display("FAIL flush_reads: %0d reads, required 1", addr_log.size());
        end
    endtask

    task automatic test_flush_handshake();
        bit ok;
        do_reset();
        ram[0] = 12'hA01; ram[1] = 12'hA02; ram[2] = 12'hA03;
        out_ready = 1'b1;
        wr_ptr = 5'd3;
        wait_valid(20, ok);
        flush = 1'b1;
        checks++;
        if (!ok || out_data !== 12'hA01) begin
            errors++;
            $display("FAIL flush_hs_data: valid=%b data=%h, required 1 a01", ok, out_data);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (rd_ptr !== 5'd3 || out_valid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_hs_ptr: rd_ptr=%0d valid=%b empty=%b, required 3 0 1", rd_ptr, out_valid, empty);
        end
    endtask

    task automatic test_reset_in_hold();
        bit ok;
        do_reset();
        ram[0] = 12'hABC;
        wr_ptr = 5'd2;
        wait_valid(20, ok);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (!ok || out_valid !== 1'b0 || rd_ptr !== 5'd0) begin
            errors++;
            $display("FAIL reset_in_hold: reached=%b valid=%b rd_ptr=%0d, required 1 0 0", ok, out_valid, rd_ptr);
        end
    endtask

`ifdef AVG4_EN
    task automatic test_avg4();
        bit ok; logic [DW-1:0] dat; logic [DW-1:0] exp; int cyc;
        do_reset();
        for (int i = 0; i < 5; i++) ram[i] = 12'(100 + 4 * i);
        exp_q.push_back(12'd106); exp_q.push_back(12'd110);
        out_ready = 1'b1;
        wr_ptr = 5'd5;
        wait_valid(40, ok);
        checks++;
        if (!ok || rd_ptr !== 5'd3) begin
            errors++;
            $display("FAIL avg_prime: valid=%b rd_ptr=%0d, required 1 3", ok, rd_ptr);
        end
        for (int i = 0; i < 2; i++) begin
            wait_hs(20, ok, dat, cyc);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL avg_timeout[%0d]: no handshake", i);
            end else begin
                exp = exp_q.pop_front();
                if (dat !== exp) begin
                    errors++;
                    $display("FAIL avg_data[%0d]: got %0d, required %0d", i, dat, exp);
                end
            end
        end
        checks++;
        if (rd_ptr !== 5'd5 || empty !== 1'b1) begin
            errors++;
            $display("FAIL avg_end: rd_ptr=%0d empty=%b, required 5 1", rd_ptr, empty);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ptr_cmp();
`ifdef AVG4_EN
        test_avg4();
`else
        test_burst();
        test_stall();
        test_wrap();
        test_flush_hold();
        test_flush_handshake();
        test_reset_in_hold();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
